// File: rtl/act_unit_scheduler_if.sv
// Bundle of request, activation-unit and response signals for act_unit_scheduler.
// The scheduler connects through the slave modport; requesters, the unit and the consumer use master.
interface act_unit_scheduler_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [16*NUM_REQ-1:0] req_data;
    logic [2*NUM_REQ-1:0]  req_sel;
    logic [15:0]           act_in;
    logic [1:0]            act_sel;
    logic [15:0]           act_out;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [15:0]           rsp_data;
    logic                  busy;
    logic [15:0]           op_count;

    modport master (
        output req_valid, req_data, req_sel, act_out, rsp_ready,
        input  req_ready, act_in, act_sel, rsp_valid, rsp_id, rsp_data, busy, op_count
    );

    modport slave (
        input  req_valid, req_data, req_sel, act_out, rsp_ready,
        output req_ready, act_in, act_sel, rsp_valid, rsp_id, rsp_data, busy, op_count
    );
endinterface

// File: rtl/act_unit_scheduler.sv
// Round-robin scheduler sharing one combinational activation unit among NUM_REQ requesters.
// Operand/select are registered before driving the unit; the result returns on a valid/ready channel.
module act_unit_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input logic               clk,
    input logic               rst_n,
    act_unit_scheduler_if.slave bus
);
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StEval = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    logic [1:0]      stateQ, stateD;
    logic [ID_W-1:0] lastGrantQ, idQ, rspIdQ;
    logic [ID_W-1:0] winner, cand;
    logic            found, grant;
    logic [15:0]     opQ, rspDataQ, opCountQ, winData;
    logic [1:0]      selQ, winSel;
    logic            rspValidQ;

    // Search starts just after the last winner so every valid requester gets a turn.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((32'(lastGrantQ) + k) % NUM_REQ);
            if (!found && bus.req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        winData = '0;
        winSel  = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (winner == ID_W'(i)) begin
                winData = bus.req_data[16*i +: 16];
                winSel  = bus.req_sel[2*i +: 2];
            end
        end
    end

    assign grant = (stateQ == StIdle) && found;

    always_comb begin
        bus.req_ready = '0;
        if (grant) begin
            bus.req_ready[winner] = 1'b1;
        end
    end

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            StIdle:  if (found) stateD = StEval;
            StEval:  stateD = StResp;
            StResp:  if (bus.rsp_ready) stateD = StIdle;
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ     <= StIdle;
            lastGrantQ <= ID_W'(NUM_REQ - 1);
            idQ        <= '0;
            opQ        <= '0;
            selQ       <= '0;
            rspValidQ  <= 1'b0;
            rspIdQ     <= '0;
            rspDataQ   <= '0;
            opCountQ   <= '0;
        end else begin
            stateQ <= stateD;
            if (grant) begin
                opQ        <= winData;
                selQ       <= winSel;
                idQ        <= winner;
                lastGrantQ <= winner;
            end
            if (stateQ == StEval) begin
                rspDataQ  <= bus.act_out;
                rspIdQ    <= idQ;
                rspValidQ <= 1'b1;
            end else if (stateQ == StResp && bus.rsp_ready) begin
                rspValidQ <= 1'b0;
                opCountQ  <= opCountQ + 16'd1;
            end
        end
    end

    assign bus.act_in    = opQ;
    assign bus.act_sel   = selQ;
    assign bus.rsp_valid = rspValidQ;
    assign bus.rsp_id    = rspIdQ;
    assign bus.rsp_data  = rspDataQ;
    assign bus.busy      = (stateQ != StIdle);
    assign bus.op_count  = opCountQ;
endmodule

// File: tb/tb_act_unit_scheduler.sv
// Bench for act_unit_scheduler: vector table, directed corner sequences and a randomized
// round-robin run checked against a transaction-level reference model.
module tb_act_unit_scheduler;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    act_unit_scheduler_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) busIf ();

    act_unit_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busIf)
    );

    // Shared activation unit stand-in; tanh is a hard clamp to +/-0x0400.
    function automatic logic [15:0] actFn(input logic [15:0] v, input logic [1:0] s);
        case (s)
            2'b00:   return v;
            2'b01:   return v[15] ? 16'h0000 : 16'h0001;
            2'b10:   return v[15] ? 16'h0000 : v;
            default: begin
                if ($signed(v) > $signed(16'h0400)) return 16'h0400;
                if ($signed(v) < $signed(16'hFC00)) return 16'hFC00;
                return v;
            end
        endcase
    endfunction

    assign busIf.act_out = actFn(busIf.act_in, busIf.act_sel);

    int errors = 0;
    int checks = 0;
    logic [15:0] expCount = '0;
    int modelLast = NUM_REQ - 1;
    logic [15:0] dArr [NUM_REQ];
    logic [1:0]  sArr [NUM_REQ];

    typedef struct {
        int          r;
        logic [15:0] d;
        logic [1:0]  s;
        logic [15:0] e;
        string       name;
    } vec_t;
    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyArr(input logic [NUM_REQ-1:0] mask);
        busIf.req_valid = mask;
        for (int i = 0; i < NUM_REQ; i++) begin
            busIf.req_data[16*i +: 16] = dArr[i];
            busIf.req_sel[2*i +: 2]    = sArr[i];
        end
    endtask

    task automatic scramble();
        for (int i = 0; i < NUM_REQ; i++) begin
            dArr[i] = 16'($urandom);
            sArr[i] = 2'($urandom);
        end
    endtask

    // Reference round-robin: first valid requester after the previous winner.
    function automatic int winnerOf(input logic [NUM_REQ-1:0] mask, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (mask[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic pulseReset();
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        expCount  = '0;
        modelLast = NUM_REQ - 1;
    endtask

    // One lone request with rsp_ready high; starts and ends between edges.
    task automatic doOne(input int r, input logic [15:0] d, input logic [1:0] s,
                         input logic [15:0] e, input string name);
        scramble();
        dArr[r] = d;
        sArr[r] = s;
        busIf.rsp_ready = 1'b1;
        applyArr(4'(1 << r));
        #1;
        chk({name, "/ready"}, busIf.req_ready, 1 << r);
        chk({name, "/idleBusy"}, busIf.busy, 0);
        tick();
        modelLast = r;
        scramble();
        applyArr('0);
        #1;
        chk({name, "/actIn"}, busIf.act_in, d);
        chk({name, "/actSel"}, busIf.act_sel, s);
        chk({name, "/evalNoRsp"}, busIf.rsp_valid, 0);
        tick();
        #1;
        chk({name, "/rspValid"}, busIf.rsp_valid, 1);
        chk({name, "/rspId"}, busIf.rsp_id, r);
        chk({name, "/rspData"}, busIf.rsp_data, e);
        tick();
        expCount++;
        #1;
        chk({name, "/rspDone"}, busIf.rsp_valid, 0);
        chk({name, "/opCount"}, busIf.op_count, expCount);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 16'h8005, 2'b10, 16'h0000, "reluNeg"};
        vecs[1] = '{2, 16'h0000, 2'b01, 16'h0001, "stepZero"};
        vecs[2] = '{2, 16'hFFFF, 2'b01, 16'h0000, "stepNeg"};
        vecs[3] = '{1, 16'h1234, 2'b00, 16'h1234, "pass"};
        vecs[4] = '{3, 16'h7FFF, 2'b10, 16'h7FFF, "reluPos"};
        vecs[5] = '{1, 16'h0000, 2'b10, 16'h0000, "reluZero"};
        vecs[6] = '{3, 16'h8000, 2'b01, 16'h0000, "stepMin"};
        vecs[7] = '{0, 16'h0200, 2'b11, 16'h0200, "tanhMid"};
        vecs[8] = '{1, 16'h7000, 2'b11, 16'h0400, "tanhHi"};
        vecs[9] = '{3, 16'h9000, 2'b11, 16'hFC00, "tanhLo"};

        busIf.req_valid = '0;
        busIf.req_data  = '0;
        busIf.req_sel   = '0;
        busIf.rsp_ready = 1'b0;

        // Reset values
        #12;
        chk("rst/rspValid", busIf.rsp_valid, 0);
        chk("rst/rspId", busIf.rsp_id, 0);
        chk("rst/rspData", busIf.rsp_data, 0);
        chk("rst/actIn", busIf.act_in, 0);
        chk("rst/actSel", busIf.act_sel, 0);
        chk("rst/opCount", busIf.op_count, 0);
        chk("rst/busy", busIf.busy, 0);
        chk("rst/reqReady", busIf.req_ready, 0);
        tick();
        rst_n = 1'b1;

        for (int v = 0; v < 10; v++) begin
            doOne(vecs[v].r, vecs[v].d, vecs[v].s, vecs[v].e, vecs[v].name);
        end

        // All four requesting continuously: strict 0,1,2,3,0 at 3-cycle spacing
        tick();
        pulseReset();
        for (int i = 0; i < NUM_REQ; i++) begin
            dArr[i] = 16'h0100 + 16'(i);
            sArr[i] = 2'b00;
        end
        applyArr('1);
        busIf.rsp_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            #1;
            chk("rr/grant", busIf.req_ready, 1 << (g % NUM_REQ));
            tick();
            #1;
            chk("rr/evalReady", busIf.req_ready, 0);
            tick();
            #1;
            chk("rr/rspId", busIf.rsp_id, g % NUM_REQ);
            chk("rr/rspData", busIf.rsp_data, 16'h0100 + 16'(g % NUM_REQ));
            tick();
        end
        applyArr('0);
        expCount = 16'd5;
        #1;
        chk("rr/opCount", busIf.op_count, expCount);

        // Backpressure with requester 1 pending
        tick();
        dArr[0] = 16'h4321; sArr[0] = 2'b00;
        dArr[1] = 16'h0555; sArr[1] = 2'b00;
        busIf.rsp_ready = 1'b0;
        applyArr(4'b0001);
        #1;
        chk("bp/grant0", busIf.req_ready, 4'b0001);
        tick();
        applyArr(4'b0010);
        #1;
        chk("bp/evalReady", busIf.req_ready, 0);
        tick();
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp/rspValid", busIf.rsp_valid, 1);
            chk("bp/rspId", busIf.rsp_id, 0);
            chk("bp/rspData", busIf.rsp_data, 16'h4321);
            chk("bp/busy", busIf.busy, 1);
            chk("bp/reqReady", busIf.req_ready, 0);
            if (c < 4) tick();
        end
        busIf.rsp_ready = 1'b1;
        #1;
        chk("bp/noEarlyGrant", busIf.req_ready, 0);
        tick();
        expCount++;
        #1;
        chk("bp/grant1", busIf.req_ready, 4'b0010);
        chk("bp/opCount", busIf.op_count, expCount);
        tick();
        applyArr('0);
        tick();
        #1;
        chk("bp/rspId1", busIf.rsp_id, 1);
        chk("bp/rspData1", busIf.rsp_data, 16'h0555);
        tick();
        expCount++;

        // Reset while in EVAL
        dArr[3] = 16'h1111; sArr[3] = 2'b00;
        applyArr(4'b1000);
        #1;
        chk("mid/grant3", busIf.req_ready, 4'b1000);
        tick();
        applyArr('0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid/rspValid", busIf.rsp_valid, 0);
        chk("mid/rspData", busIf.rsp_data, 0);
        chk("mid/busy", busIf.busy, 0);
        chk("mid/actIn", busIf.act_in, 0);
        chk("mid/opCount", busIf.op_count, 0);
        #1;
        rst_n = 1'b1;
        expCount = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            dArr[i] = 16'h0A00 + 16'(i);
            sArr[i] = 2'b00;
        end
        applyArr('1);
        #1;
        chk("mid/firstGrant", busIf.req_ready, 4'b0001);
        tick();
        applyArr('0);
        #1;
        chk("mid/noStale", busIf.rsp_valid, 0);
        tick();
        #1;
        chk("mid/rspId", busIf.rsp_id, 0);
        chk("mid/rspData", busIf.rsp_data, 16'h0A00);
        tick();
        expCount++;
        #1;
        chk("mid/opCount1", busIf.op_count, expCount);

        // op_count wrap: preload near the top, then complete three operations
        force dut.opCountQ = 16'hFFFD;
        #1;
        release dut.opCountQ;
        expCount = 16'hFFFD;
        for (int w = 0; w < 3; w++) begin
            doOne(2, 16'h0042, 2'b00, 16'h0042, "wrap");
        end
        chk("wrap/zero", busIf.op_count, 16'h0000);

        // Randomized traffic against the round-robin reference model
        tick();
        pulseReset();
        for (int t = 0; t < 200; t++) begin
            logic [NUM_REQ-1:0] mask;
            logic [15:0] expD, opD;
            logic [1:0]  opS;
            int w;
            int idles;
            idles = $urandom_range(0, 2);
            for (int n = 0; n < idles; n++) begin
                applyArr('0);
                #1;
                chk("rnd/idleReady", busIf.req_ready, 0);
                chk("rnd/idleBusy", busIf.busy, 0);
                tick();
            end
            scramble();
            mask = 4'($urandom_range(1, 15));
            w = winnerOf(mask, modelLast);
            opD = dArr[w];
            opS = sArr[w];
            expD = actFn(opD, opS);
            applyArr(mask);
            #1;
            chk("rnd/grant", busIf.req_ready, 1 << w);
            tick();
            modelLast = w;
            scramble();
            applyArr(4'($urandom));
            #1;
            chk("rnd/evalReady", busIf.req_ready, 0);
            chk("rnd/actIn", busIf.act_in, opD);
            chk("rnd/actSel", busIf.act_sel, opS);
            chk("rnd/evalNoRsp", busIf.rsp_valid, 0);
            tick();
            for (int n = 0; n < 16; n++) begin
                busIf.rsp_ready = (n >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
                applyArr(4'($urandom));
                #1;
                chk("rnd/rspValid", busIf.rsp_valid, 1);
                chk("rnd/rspId", busIf.rsp_id, w);
                chk("rnd/rspData", busIf.rsp_data, expD);
                chk("rnd/respReady", busIf.req_ready, 0);
                tick();
                if (busIf.rsp_ready) break;
            end
            expCount++;
            applyArr('0);
            #1;
            chk("rnd/rspDone", busIf.rsp_valid, 0);
            chk("rnd/opCount", busIf.op_count, expCount);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/act_unit_scheduler.md
Name: act_unit_scheduler

Overview:
- Round-robin scheduler that shares one activation-function datapath (16-bit value in, 2-bit function select, 16-bit result out, purely combinational) among NUM_REQ neuron requesters.
- Arbitrates, latches the winner's operand and select, and drives the shared unit from registers.
- Captures the result and returns it with the requester ID over a valid/ready response channel.
- Sits between the neuron accumulators and the single instantiated activation unit.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, 2, width of requester ID; must equal ceil(log2(NUM_REQ)), minimum 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
- req_data  input  16*NUM_REQ  operand; requester i occupies bits [16i+15:16i].
- req_sel  input  2*NUM_REQ  function select; requester i occupies bits [2i+1:2i]. Encoding: 00 pass, 01 step, 10 relu, 11 tanh.
- act_in  output  16  operand to the shared activation unit.
- act_sel  output  2  select to the shared activation unit.
- act_out  input  16  result from the shared activation unit (combinational of act_in/act_sel).
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  ID_W  index of the requester that owns the response.
- rsp_data  output  16  activation result.
- busy  output  1  high whenever the FSM is not in IDLE.
- op_count  output  16  number of completed responses; wraps 0xFFFF->0x0000.

Behaviour:
- Reset (async, rst_n=0), all registers cleared:
  - state=IDLE; rsp_valid=0; rsp_id=0; rsp_data=0.
  - act_in=0; act_sel=00; op_count=0; busy=0; req_ready=0.
  - Round-robin pointer last_grant=NUM_REQ-1, so requester 0 has priority first.
  - Reset asserted mid-operation discards the in-flight operation; no response is produced.
- FSM has three states: IDLE, EVAL, RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching last_grant+1, last_grant+2, ... modulo NUM_REQ.
  - req_ready[winner]=1 combinationally in the same cycle; all other bits 0. If no requester is valid, all bits are 0.
  - On the handshake edge: latch op_reg=req_data[winner], sel_reg=req_sel[winner], id_reg=winner; set last_grant=winner; go to EVAL.
- EVAL (exactly 1 cycle):
  - act_in=op_reg and act_sel=sel_reg (these outputs are always driven from the registers).
  - At the clock edge: rsp_data<=act_out, rsp_id<=id_reg, rsp_valid<=1; go to RESP.
- RESP:
  - rsp_valid, rsp_data and rsp_id are held stable until rsp_ready=1.
  - On an edge with rsp_valid&rsp_ready: rsp_valid<=0, op_count<=op_count+1, go to IDLE.
  - req_ready=0 throughout EVAL and RESP.
- Timing:
  - Latency: grant at edge N, rsp_valid high after edge N+1.
  - Minimum issue interval is 3 cycles with rsp_ready held high.
- req_ready is never asserted without the matching req_valid.
- A requester that drops req_valid before being granted loses its turn silently.
- req_data and req_sel are sampled only at the handshake edge.
- Simultaneous requests: strict round-robin.
  - A requester granted at edge N cannot win again until every other valid requester has been served.
  - A lone valid requester wins every round.
- Activation results follow the shared unit's definitions:
  - step: 0x0001 if the operand is non-negative, else 0x0000.
  - relu: operand if non-negative, else 0x0000.
  - tanh: per the shared unit; the scheduler passes act_out through unchanged.

Test Plan:
- Reset then a single request, with rsp_ready=1: req_valid=0001, req_data[0]=0x8005, req_sel[0]=10 -> req_ready=0001 in the same cycle; two cycles later rsp_valid=1, rsp_id=0, rsp_data=0x0000 (relu of a negative); op_count=1.
- All four requesting continuously, all sel=00, data_i=0x0100+i, rsp_ready=1 -> grants in order 0,1,2,3,0 at 3-cycle spacing; rsp_data=0x0100,0x0101,0x0102,0x0103 with matching rsp_id.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid rises, with req_valid[1]=1 pending -> rsp fields stable, busy=1, req_ready=0; the grant to requester 1 occurs only in the cycle after rsp_ready=1.
- Step function on requester 2: req_data=0x0000, sel=01 -> rsp_data=0x0001. Repeat with req_data=0xFFFF -> rsp_data=0x0000.
- Reset mid-operation: assert rst_n=0 while in EVAL -> all outputs return to reset values immediately; after release, req_valid=1111 -> first grant goes to requester 0; no stale response appears.
- op_count wrap: force 65536 completions -> op_count returns to 0x0000 with no other effect.
